// File: rtl/dec_pkg.sv
// dec_pkg: shared types for the select decoder pipeline.
//   dec_mode_e  - decode mode carried on in_mode (all four codes defined)
//   dec_state_e - control state of the output stage
package dec_pkg;

  typedef enum logic [1:0] {
    DEC_ONEHOT = 2'd0,
    DEC_THERMO = 2'd1,
    DEC_SCAN   = 2'd2,
    DEC_OFF    = 2'd3
  } dec_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_SCAN = 2'd2
  } dec_state_e;

endpackage

// File: rtl/dec_word_comb.sv
// dec_word_comb: purely combinational select -> word decoder.
//   sel_i  in  SEL_W  select value s
//   mode_i in  2      dec_mode_e code
//   data_o out OUT_W  decoded word (zero when out of range)
//   err_o  out 1      s >= OUT_W in any mode other than OFF
// In SCAN mode this produces the first beat of a scan (bit 0); the later
// scan beats are produced by driving ONEHOT with the running index.
module dec_word_comb
  import dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] data_o,
  output logic             err_o
);

  dec_mode_e mode_s;
  int        sel_v_s;

  assign mode_s = dec_mode_e'(mode_i);

  // Range check and per-bit decode of the requested word.
  always_comb begin
    sel_v_s = 32'(sel_i);
    err_o   = 1'b0;
    data_o  = '0;
    if ((mode_s != DEC_OFF) && (sel_v_s >= OUT_W)) begin
      err_o = 1'b1;
    end else begin
      for (int i = 0; i < OUT_W; i++) begin
        case (mode_s)
          DEC_ONEHOT: data_o[i] = (sel_v_s == i);
          DEC_THERMO: data_o[i] = (i <= sel_v_s);
          DEC_SCAN:   data_o[i] = (i == 0);
          DEC_OFF:    data_o[i] = 1'b0;
          default:    data_o[i] = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/dec_stream_pipe.sv
// dec_stream_pipe: registered, valid/ready select decoder.
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   request handshake; in_sel (SEL_W), in_mode (2)
//   out_valid/out_ready beat handshake
//   out_data  OUT_W     decoded word
//   out_idx   SEL_W     set-bit index (ONEHOT/SCAN), s (THERMO), 0 (OFF/err)
//   out_last  1         final beat of the transaction
//   out_err   1         select out of range on this beat
// A SCAN request of s emits s+1 one-hot beats; every other request (and any
// out-of-range select) emits a single beat. One output register stage.
module dec_stream_pipe
  import dec_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [SEL_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_err
);

  dec_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic             accept_s;
  logic [SEL_W-1:0] idx_inc_s;
  logic [OUT_W-1:0] ld_data_s, scan_data_s;
  logic             ld_err_s, scan_err_s;
  dec_mode_e        ld_mode_s;

  assign ld_mode_s = dec_mode_e'(in_mode);
  // idx < s < OUT_W <= 2^SEL_W, so the increment never wraps.
  assign idx_inc_s = idx_q + SEL_W'(1);

  // rst_n is folded in so no request is taken while reset is held.
  assign in_ready = rst_n & (state_q != ST_SCAN) & (~valid_q | out_ready);
  assign accept_s = in_valid & in_ready;

  dec_word_comb #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_load_dec (
    .sel_i  (in_sel),
    .mode_i (in_mode),
    .data_o (ld_data_s),
    .err_o  (ld_err_s)
  );

  dec_word_comb #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_scan_dec (
    .sel_i  (idx_inc_s),
    .mode_i (DEC_ONEHOT),
    .data_o (scan_data_s),
    .err_o  (scan_err_s)
  );

  // Next-state and next-output selection for load, scan step and drain.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_ONE: begin
        if (accept_s) begin
          valid_d = 1'b1;
          data_d  = ld_data_s;
          err_d   = ld_err_s;
          sel_d   = in_sel;
          last_d  = 1'b1;
          state_d = ST_ONE;
          if (ld_err_s) begin
            idx_d = '0;
          end else begin
            case (ld_mode_s)
              DEC_ONEHOT: idx_d = in_sel;
              DEC_THERMO: idx_d = in_sel;
              DEC_SCAN: begin
                idx_d = '0;
                // A scan of s=0 is a single beat.
                if (in_sel != '0) begin
                  last_d  = 1'b0;
                  state_d = ST_SCAN;
                end else begin
                  last_d  = 1'b1;
                end
              end
              DEC_OFF:    idx_d = '0;
              default:    idx_d = '0;
            endcase
          end
        end else if ((state_q == ST_ONE) && out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          if (idx_q == sel_q) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_inc_s;
            data_d = scan_data_s;
            err_d  = scan_err_s;
            last_d = (idx_inc_s == sel_q);
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_dec_stream_pipe.sv
// tb_dec_stream_pipe: two instances (OUT_W=8 and OUT_W=6) driven by directed
// requests; a beat-queue model predicts every output beat and in_ready.
module tb_dec_stream_pipe;

  typedef struct {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
    logic       err;
    logic       multi;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [2:0] in_sel    [2];
  logic [1:0] in_mode   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic [2:0] out_idx   [2];
  logic       out_last  [2];
  logic       out_err   [2];
  logic [7:0] a_data;
  logic [5:0] b_data;

  int    nvec = 0;
  int    nfail = 0;
  int    consumed [2];
  bit    tog [2];
  beat_t q0 [$];
  beat_t q1 [$];

  dec_stream_pipe #(.SEL_W(3), .OUT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sel(in_sel[0]), .in_mode(in_mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(a_data),
    .out_idx(out_idx[0]), .out_last(out_last[0]), .out_err(out_err[0])
  );

  dec_stream_pipe #(.SEL_W(3), .OUT_W(6)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sel(in_sel[1]), .in_mode(in_mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(b_data),
    .out_idx(out_idx[1]), .out_last(out_last[1]), .out_err(out_err[1])
  );

  assign out_data[0] = a_data;
  assign out_data[1] = {2'b00, b_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out_ready per instance: steady high, or toggling when tog is set.
  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) out_ready[d] = tog[d] ? !out_ready[d] : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(input int d, input beat_t b);
    if (d == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  // Model: list of beats a request must produce, from the decode rules.
  task automatic expect_req(input int d, input logic [1:0] mode, input int s);
    int    outw;
    beat_t b;
    outw = (d == 0) ? 8 : 6;
    if (mode != 2'd3 && s >= outw) begin
      b = '{8'h00, 3'd0, 1'b1, 1'b1, 1'b0}; put(d, b);
    end else begin
      case (mode)
        2'd0: begin b = '{8'(1 << s), 3'(s), 1'b1, 1'b0, 1'b0}; put(d, b); end
        2'd1: begin b = '{8'((1 << (s + 1)) - 1), 3'(s), 1'b1, 1'b0, 1'b0}; put(d, b); end
        2'd2: begin
          for (int k = 0; k <= s; k++) begin
            b = '{8'(1 << k), 3'(k), (k == s), 1'b0, (s > 0)};
            put(d, b);
          end
        end
        default: begin b = '{8'h00, 3'd0, 1'b1, 1'b0, 1'b0}; put(d, b); end
      endcase
    end
  endtask

  task automatic check_dut(input int d);
    beat_t f;
    int    sz;
    bit    exp_rdy;
    string p;
    p  = $sformatf("d%0d", d);
    sz = (d == 0) ? q0.size() : q1.size();
    chk({p, " out_valid"}, 32'(out_valid[d]), 32'(sz > 0));
    if (sz > 0) begin
      f = (d == 0) ? q0[0] : q1[0];
      exp_rdy = !f.multi && out_ready[d];
      chk({p, " out_data"}, 32'(out_data[d]), 32'(f.data));
      chk({p, " out_idx"},  32'(out_idx[d]),  32'(f.idx));
      chk({p, " out_last"}, 32'(out_last[d]), 32'(f.last));
      chk({p, " out_err"},  32'(out_err[d]),  32'(f.err));
      if (out_ready[d]) begin
        if (d == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        consumed[d]++;
      end
    end else begin
      exp_rdy = 1'b1;
    end
    chk({p, " in_ready"}, 32'(in_ready[d]), 32'(exp_rdy));
    if (in_valid[d] && in_ready[d]) expect_req(d, in_mode[d], 32'(in_sel[d]));
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      check_dut(0);
      check_dut(1);
    end
  end

  task automatic send(input int d, input logic [1:0] m, input logic [2:0] s, output int cyc);
    bit rdy;
    rdy = 1'b0;
    cyc = 0;
    in_valid[d] = 1'b1;
    in_mode[d]  = m;
    in_sel[d]   = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = in_ready[d];
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) break;
    end
    if (!rdy) chk($sformatf("d%0d accept timeout", d), 32'd0, 32'd1);
    in_valid[d] = 1'b0;
  endtask

  initial begin
    int cyc;
    int total;
    int c0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_sel[d] = 3'd0; in_mode[d] = 2'd0;
      tog[d] = 1'b0; consumed[d] = 0;
    end
    in_valid[0] = 1'b1;
    #12;
    // 1: reset state
    chk("rst in_ready", 32'(in_ready[0]), 32'd0);
    chk("rst out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst out_data", 32'(out_data[0]), 32'd0);
    chk("rst out_idx", 32'(out_idx[0]), 32'd0);
    chk("rst out_last", 32'(out_last[0]), 32'd0);
    chk("rst out_err", 32'(out_err[0]), 32'd0);
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;

    // 2: ONEHOT sel 5, then a back-to-back stream 0..7
    send(0, 2'd0, 3'd5, cyc);
    chk("oh5 data", 32'(out_data[0]), 32'h20);
    chk("oh5 idx", 32'(out_idx[0]), 32'd5);
    chk("oh5 last", 32'(out_last[0]), 32'd1);
    chk("oh5 err", 32'(out_err[0]), 32'd0);
    total = 0;
    for (int s = 0; s < 8; s++) begin
      send(0, 2'd0, 3'(s), cyc);
      total += cyc;
    end
    chk("stream cycles", 32'(total), 32'd8);
    repeat (3) @(posedge clk); #1;

    // 3: THERMO
    send(0, 2'd1, 3'd3, cyc);
    chk("th3 data", 32'(out_data[0]), 32'h0F);
    chk("th3 last", 32'(out_last[0]), 32'd1);
    send(0, 2'd1, 3'd7, cyc);
    chk("th7 data", 32'(out_data[0]), 32'hFF);
    repeat (3) @(posedge clk); #1;

    // 4: SCAN sel 3 under a toggling out_ready
    tog[0] = 1'b1;
    c0 = consumed[0];
    send(0, 2'd2, 3'd3, cyc);
    chk("scan3 first data", 32'(out_data[0]), 32'h01);
    chk("scan3 first last", 32'(out_last[0]), 32'd0);
    repeat (15) @(posedge clk); #1;
    chk("scan3 beats", 32'(consumed[0] - c0), 32'd4);
    tog[0] = 1'b0;
    repeat (3) @(posedge clk); #1;

    // 5: OUT_W=6 out-of-range
    send(1, 2'd0, 3'd6, cyc);
    chk("b oh6 data", 32'(out_data[1]), 32'd0);
    chk("b oh6 err", 32'(out_err[1]), 32'd1);
    chk("b oh6 last", 32'(out_last[1]), 32'd1);
    chk("b oh6 idx", 32'(out_idx[1]), 32'd0);
    send(1, 2'd2, 3'd7, cyc);
    c0 = consumed[1];
    chk("b scan7 err", 32'(out_err[1]), 32'd1);
    repeat (5) @(posedge clk); #1;
    chk("b scan7 beats", 32'(consumed[1] - c0), 32'd1);

    // 6: reset during SCAN beat 2 of sel 7
    send(0, 2'd2, 3'd7, cyc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scan7 beat2 data", 32'(out_data[0]), 32'h04);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async drop valid", 32'(out_valid[0]), 32'd0);
    chk("async drop ready", 32'(in_ready[0]), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst idle", 32'(out_valid[0]), 32'd0);
    send(0, 2'd0, 3'd1, cyc);
    chk("post rst oh1", 32'(out_data[0]), 32'h02);
    chk("post rst idx", 32'(out_idx[0]), 32'd1);
    repeat (5) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
